eth_fcs_tx_ctrl: RTL and testbench
==================================

Name: eth_fcs_tx_ctrl

Overview:
Transmit-side sequencer for the nibble-wide CRC-32 engine in the Ethernet TX path. Accepts a frame as a nibble stream, starting at the destination MAC and excluding preamble/SFD. Forwards the frame, feeds each nibble to the CRC engine, then appends the 8-nibble FCS and enforces the inter-frame gap. Sits between the frame builder and the MII/RMII nibble serializer.

Parameters:
IFG_NIBBLES, 24, idle nibble slots enforced after each FCS (96 bit times)
MIN_NIBBLES, 120, minimum payload nibbles before FCS (60 bytes); used only with padding enabled

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
s_data  in  4  frame nibble, low nibble of each byte first, bit0 = first on wire
s_valid  in  1  upstream nibble valid
s_last  in  1  marks final payload nibble of frame
s_ready  out  1  controller accepts s_data this cycle
m_data  out  4  nibble to serializer
m_valid  out  1  m_data valid
m_last  out  1  final FCS nibble
m_ready  in  1  serializer consumes m_data this cycle
busy  out  1  high from first accepted nibble until IFG ends
frame_done  out  1  one-cycle pulse when last FCS nibble handshakes

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0, frame_done=0. State=IDLE. CRC register = 32'hFFFFFFFF. rst mid-frame aborts the frame; no partial FCS is emitted.
- Handshakes: a transfer occurs when valid&ready. m_valid, once high, holds with m_data/m_last stable until m_ready.
- Output stage: single register. s_ready = (state is IDLE or DATA) & (!m_valid | m_ready). Input-to-output latency is 1 cycle. Sustains 1 nibble/cycle.
- CRC feed: on every accepted s nibble (including pad nibbles), the engine steps with data_in = bit-reverse(s_data). The engine is synchronously re-initialised to all-ones on entry to IDLE.
- FSM:
  - IDLE: on a handshake, go to DATA (or FCS if s_last); busy=1.
  - DATA: forward nibbles and count them in an 11-bit saturating counter. On an s_last handshake, go to FCS (or PAD, see Optional Feature).
  - FCS: snapshot F = ~crc on entry. Emit 8 nibbles, nibble i (0..7) = bit-reverse(F[31-4i -: 4]). m_last=1 on i=7; frame_done pulses on its handshake. Then go to IFG.
  - IFG: count IFG_NIBBLES cycles with m_valid=0 and s_ready=0, then go to IDLE; busy=0.
- Backpressure in FCS/PAD: the counter advances only on m handshakes.
- s_valid while s_ready=0: held upstream, no effect.
- s_last on the first nibble: legal; that 1-nibble frame gets a full FCS.
- IFG_NIBBLES=0: go FCS→IDLE directly.

Optional Feature:
Macro ETH_FCS_PAD_EN.
- Defined: if the payload count is below MIN_NIBBLES at s_last, enter PAD. PAD emits 0x0 nibbles, fed to the CRC, until the count reaches MIN_NIBBLES, then goes to FCS. s_ready=0 in PAD.
- Undefined: the PAD state and comparator are absent. Short frames go straight to FCS unpadded.

Decomposition:
- Package eth_tx_pkg holds: state enum (IDLE, DATA, PAD, FCS, IFG), CRC32_INIT=32'hFFFFFFFF, FCS_NIBBLES=8, and a bit-reverse-nibble function.
- One sub-module, crc32_nibble_lfsr: polynomial 0x04C11DB7, 4-bit step, synchronous init and enable inputs.
- FSM, counters and output register live in the top module.

Test Plan:
- ASCII "123456789" as 18 nibbles (1,3,2,3,...,9,3), m_ready=1 → output = 18 data nibbles then FCS 6,2,9,3,4,F,B,C; m_last on C; frame_done 1 cycle later.
- Same frame with m_ready toggling 1-0-1-0 → identical nibble sequence; no drops or duplicates; m_data stable while stalled.
- Two back-to-back frames → s_ready=0 for exactly 24 cycles after the first frame's final FCS handshake; the second FCS is correct (CRC re-initialised).
- 1-nibble frame 0x0 with s_last → 1 data nibble then 8 FCS nibbles; m_last only on the 9th output.
- rst asserted mid-DATA → all outputs 0 next edge; the following frame's FCS matches the golden model.
- ETH_FCS_PAD_EN, 20-nibble frame → 100 zero pad nibbles, then FCS over 120 nibbles matches the golden model; without the macro, FCS directly follows nibble 20.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// -----------------------------------------------------------------------------
// eth_tx_pkg
// Shared types and constants for the Ethernet TX FCS sequencer.
//   state_e     : sequencer states (PAD is only reachable when ETH_FCS_PAD_EN
//                 is defined)
//   CRC32_INIT  : CRC register value at frame start
//   CRC32_POLY  : CRC-32 generator polynomial, MSB-first form
//   FCS_NIBBLES : length of the appended FCS in nibbles
//   bitrev4     : nibble bit reversal (wire order <-> MSB-first order)
// -----------------------------------------------------------------------------
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    PAD  = 3'd2,
    FCS  = 3'd3,
    IFG  = 3'd4
  } state_e;

  localparam logic [31:0] CRC32_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY  = 32'h04C1_1DB7;
  localparam int          FCS_NIBBLES = 8;

  function automatic logic [3:0] bitrev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

endpackage

// File: rtl/crc32_nibble_lfsr.sv
// -----------------------------------------------------------------------------
// crc32_nibble_lfsr
// MSB-first CRC-32 register (poly 0x04C11DB7) advancing four bits per enabled
// cycle. data_i[3] is shifted in first, so callers feeding wire-order nibbles
// must bit-reverse them.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (register -> all ones)
//   init_i    : synchronous re-initialisation to all ones (wins over en_i)
//   en_i      : advance the register by one nibble
//   data_i    : nibble to absorb, MSB-first
//   crc_o     : current register contents
// -----------------------------------------------------------------------------
module crc32_nibble_lfsr
  import eth_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [3:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    for (int b = 3; b >= 0; b--) begin
      if (crc_d[31] ^ data_i[b]) begin
        crc_d = {crc_d[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        crc_d = {crc_d[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC32_INIT;
    end else if (init_i) begin
      crc_q <= CRC32_INIT;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/eth_fcs_tx_ctrl.sv
// -----------------------------------------------------------------------------
// eth_fcs_tx_ctrl
// Ethernet TX sequencer: forwards a nibble-stream frame (DA onward), runs it
// through the CRC-32 engine, appends the 8-nibble FCS and holds off the next
// frame for IFG_NIBBLES idle slots.
// Build option: define ETH_FCS_PAD_EN to zero-pad short frames to MIN_NIBBLES
// payload nibbles before the FCS.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   s_data_i      : frame nibble, wire bit order (bit0 first on the wire)
//   s_valid_i     : upstream nibble valid
//   s_last_i      : final payload nibble of the frame
//   s_ready_o     : nibble accepted this cycle when s_valid_i is high
//   m_data_o      : nibble to the serializer
//   m_valid_o     : m_data_o valid, held with data until m_ready_i
//   m_last_o      : final FCS nibble
//   m_ready_i     : serializer consumes m_data_o this cycle
//   busy_o        : first accepted nibble until end of the inter-frame gap
//   frame_done_o  : one-cycle pulse after the last FCS nibble handshakes
//
// state | meaning
// IDLE  | waiting for the first nibble of a frame
// DATA  | forwarding payload nibbles into the CRC
// PAD   | emitting zero pad nibbles (ETH_FCS_PAD_EN only)
// FCS   | emitting the 8 complemented, bit-reversed CRC nibbles
// IFG   | enforcing the idle gap, no input or output traffic
// -----------------------------------------------------------------------------
module eth_fcs_tx_ctrl
  import eth_tx_pkg::*;
#(
  parameter int IFG_NIBBLES = 24
`ifdef ETH_FCS_PAD_EN
  ,
  parameter int MIN_NIBBLES = 120
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] s_data_i,
  input  logic       s_valid_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  output logic [3:0] m_data_o,
  output logic       m_valid_o,
  output logic       m_last_o,
  input  logic       m_ready_i,
  output logic       busy_o,
  output logic       frame_done_o
);

  localparam logic [15:0] IFG_LOAD = (IFG_NIBBLES > 0) ? 16'(IFG_NIBBLES - 1) : 16'd0;
  localparam logic [3:0]  FCS_END  = 4'(FCS_NIBBLES);
  localparam logic [3:0]  FCS_LAST = 4'(FCS_NIBBLES - 1);

  state_e      state_q;
  logic [3:0]  m_data_q;
  logic        m_valid_q;
  logic        m_last_q;
  logic        busy_q;
  logic        frame_done_q;
  logic        run_q;      // keeps s_ready low while and just after reset
  logic [3:0]  fcs_idx_q;
  logic [15:0] ifg_q;

  logic        slot_free;
  logic        s_fire;
  logic        m_fire;
  logic        last_fcs;
  logic        pad_fire;
  logic        crc_init;
  logic        crc_en;
  logic [3:0]  crc_data;
  logic [31:0] crc;
  logic [31:0] fcs_word;
  logic [3:0]  fcs_nib;

  assign slot_free = !m_valid_q || m_ready_i;
  assign s_ready_o = run_q && (state_q == IDLE || state_q == DATA) && slot_free;
  assign s_fire    = s_valid_i && s_ready_o;
  assign m_fire    = m_valid_q && m_ready_i;
  assign last_fcs  = (state_q == FCS) && m_fire && m_last_q;

`ifdef ETH_FCS_PAD_EN
  // Payload count, saturating; only the pad comparator consumes it.
  logic [10:0] cnt_q;
  logic [10:0] cnt_d;
  assign cnt_d    = (state_q == IDLE) ? 11'd1 :
                    (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  assign pad_fire = (state_q == PAD) && slot_free;
`else
  assign pad_fire = 1'b0;
`endif

  // CRC re-initialises on every entry to IDLE.
  assign crc_init = ((state_q == IFG) && (ifg_q == 16'd0)) ||
                    (last_fcs && (IFG_NIBBLES == 0));
  assign crc_en   = s_fire || pad_fire;
  assign crc_data = pad_fire ? 4'h0 : bitrev4(s_data_i);

  crc32_nibble_lfsr u_crc (
    .clk    (clk),
    .rst    (rst),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (crc_data),
    .crc_o  (crc)
  );

  // The CRC register is frozen throughout FCS, so its complement is the
  // snapshot taken on entry.
  assign fcs_word = ~crc;

  always_comb begin
    fcs_nib = 4'h0;
    for (int i = 0; i < FCS_NIBBLES; i++) begin
      if (fcs_idx_q == 4'(i)) begin
        fcs_nib = bitrev4(fcs_word[31-4*i -: 4]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      m_data_q     <= 4'h0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      run_q        <= 1'b0;
      fcs_idx_q    <= 4'd0;
      ifg_q        <= 16'd0;
`ifdef ETH_FCS_PAD_EN
      cnt_q        <= 11'd0;
`endif
    end else begin
      run_q        <= 1'b1;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE, DATA: begin
          if (s_fire) begin
            m_data_q  <= s_data_i;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b1;
            fcs_idx_q <= 4'd0;
`ifdef ETH_FCS_PAD_EN
            cnt_q     <= cnt_d;
            if (s_last_i) begin
              state_q <= (cnt_d < 11'(MIN_NIBBLES)) ? PAD : FCS;
            end else begin
              state_q <= DATA;
            end
`else
            state_q   <= s_last_i ? FCS : DATA;
`endif
          end else if (m_fire) begin
            m_valid_q <= 1'b0;
          end
        end
`ifdef ETH_FCS_PAD_EN
        PAD: begin
          if (pad_fire) begin
            m_data_q  <= 4'h0;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            cnt_q     <= cnt_d;
            if (cnt_d >= 11'(MIN_NIBBLES)) begin
              state_q <= FCS;
            end
          end
        end
`endif
        FCS: begin
          if (last_fcs) begin
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b1;
            fcs_idx_q    <= 4'd0;
            if (IFG_NIBBLES == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= IFG;
              ifg_q   <= IFG_LOAD;
            end
          end else if (slot_free && fcs_idx_q != FCS_END) begin
            m_data_q  <= fcs_nib;
            m_valid_q <= 1'b1;
            m_last_q  <= (fcs_idx_q == FCS_LAST);
            fcs_idx_q <= fcs_idx_q + 4'd1;
          end
        end
        IFG: begin
          if (ifg_q == 16'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            ifg_q <= ifg_q - 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_data_o     = m_data_q;
  assign m_valid_o    = m_valid_q;
  assign m_last_o     = m_last_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_eth_fcs_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eth_fcs_tx_ctrl
// Directed frames against a reference model: expected output nibbles come from
// a reflected (LSB-first) CRC-32 computed over the frame nibbles and queued per
// frame; a per-cycle compare process checks outputs, hold-under-stall,
// frame_done timing and the inter-frame gap length.
// -----------------------------------------------------------------------------
module tb_eth_fcs_tx_ctrl;

  localparam int IFG  = 24;
  localparam int MINN = 120;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] s_data = 4'h0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b0;
  logic       s_ready;
  logic [3:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       busy;
  logic       frame_done;

  eth_fcs_tx_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_last_i     (s_last),
    .s_ready_o    (s_ready),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_last_o     (m_last),
    .m_ready_i    (m_ready),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0: m_ready always high, 1: m_ready toggles

  logic [4:0] exp_q[$];   // {last, nibble}
  logic [3:0] hist[8];
  logic [4:0] e;
  int         out_cnt = 0;
  int         last_frame_cnt = 0;
  bit         gap_on = 0;
  int         gap = 0;
  bit         prev_stall = 0;
  bit         prev_last_hs = 0;
  bit         prev_mlast = 0;
  logic [3:0] prev_data = 4'h0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Reflected CRC-32 over wire-order nibbles; returns the FCS value (~crc).
  function automatic logic [31:0] fcs_of(input logic [3:0] n[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (n[i]) begin
      c ^= {28'd0, n[i]};
      repeat (4) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  always @(posedge clk) begin
    #1;
    if (mode == 0) m_ready = 1'b1;
    else           m_ready = ~m_ready;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall   = 0;
      prev_last_hs = 0;
      gap_on       = 0;
      out_cnt      = 0;
    end else begin
      chk(frame_done == prev_last_hs, "frame_done", 32'(frame_done), 32'(prev_last_hs));
      if (prev_stall)
        chk(m_valid && m_data == prev_data && m_last == prev_mlast, "hold",
            {m_valid, m_last, m_data}, {1'b1, prev_mlast, prev_data});
      if (gap_on) begin
        if (s_ready) begin
          chk(gap == IFG, "ifg_gap", gap, IFG);
          chk(!busy, "busy_after_ifg", 32'(busy), 0);
          gap_on = 0;
        end else begin
          chk(busy, "busy_in_ifg", 32'(busy), 1);
          gap++;
        end
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_out", {m_last, m_data}, 0);
        end else begin
          e = exp_q.pop_front();
          chk(m_data == e[3:0], "m_data", m_data, e[3:0]);
          chk(m_last == e[4], "m_last", m_last, e[4]);
        end
        out_cnt++;
        for (int i = 0; i < 7; i++) hist[i] = hist[i+1];
        hist[7] = m_data;
        if (m_last) begin
          last_frame_cnt = out_cnt;
          out_cnt = 0;
          gap_on  = 1;
          gap     = 0;
        end
      end
      prev_last_hs = m_valid && m_ready && m_last;
      prev_stall   = m_valid && !m_ready;
      prev_data    = m_data;
      prev_mlast   = m_last;
    end
  end

  task automatic send(input logic [3:0] nibs[$], input int abort_at);
    logic [3:0]  crcin[$];
    logic [31:0] f;
    int          n;
    int          b;
    bit          hs;
    n = (abort_at < 0) ? nibs.size() : abort_at;
    crcin = nibs;
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, nibs[i]});
    if (abort_at < 0) begin
`ifdef ETH_FCS_PAD_EN
      while (crcin.size() < MINN) begin
        crcin.push_back(4'h0);
        exp_q.push_back(5'h00);
      end
`endif
      f = fcs_of(crcin);
      for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, f[4*i +: 4]});
    end
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = nibs[i];
      s_last  = (abort_at < 0) && (i == n - 1);
      b = 0;
      hs = 0;
      while (!hs && b < 2000) begin
        @(negedge clk);
        hs = s_ready;
        b++;
      end
      if (!hs) chk(0, "s_ready_timeout", b, 0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((exp_q.size() != 0 || gap_on || busy) && b < 3000) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk(b < 3000, "drain_timeout", b, 3000);
  endtask

  task automatic chk_zero(input string tag);
    chk(!s_ready,    {tag, "_s_ready"},    32'(s_ready), 0);
    chk(!m_valid,    {tag, "_m_valid"},    32'(m_valid), 0);
    chk(!m_last,     {tag, "_m_last"},     32'(m_last), 0);
    chk(m_data == 0, {tag, "_m_data"},     32'(m_data), 0);
    chk(!busy,       {tag, "_busy"},       32'(busy), 0);
    chk(!frame_done, {tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  function automatic logic [31:0] hist_word();
    logic [31:0] w = 0;
    for (int i = 0; i < 8; i++) w = {w[27:0], hist[i]};
    return w;
  endfunction

  initial begin
    logic [3:0] f9[$];
    logic [3:0] fb[$];
    logic [3:0] f1[$];
    logic [3:0] f20[$];
    for (int c = 1; c <= 9; c++) begin
      f9.push_back(4'(c));
      f9.push_back(4'h3);
    end
    for (int i = 0; i < 10; i++) fb.push_back(4'(i * 3 + 1));
    f1.push_back(4'h0);
    for (int i = 0; i < 20; i++) f20.push_back(4'(i + 5));

    chk(fcs_of(f9) == 32'hCBF4_3926, "model_check_value", fcs_of(f9), 32'hCBF4_3926);

    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // "123456789", serializer always ready
    mode = 0;
    send(f9, -1);
    wait_idle();
    chk(hist_word() == 32'h6293_4FBC, "fcs_123456789", hist_word(), 32'h6293_4FBC);
    chk(last_frame_cnt == 26, "frame_len_26", last_frame_cnt, 26);

    // same frame under alternating backpressure
    mode = 1;
    send(f9, -1);
    wait_idle();
    chk(hist_word() == 32'h6293_4FBC, "fcs_stalled", hist_word(), 32'h6293_4FBC);
    mode = 0;

    // back-to-back frames
    send(f9, -1);
    send(fb, -1);
    wait_idle();

    // single-nibble frame
    send(f1, -1);
    wait_idle();
    chk(last_frame_cnt == 9, "one_nibble_len", last_frame_cnt, 9);

    // reset mid-frame, then a clean frame
    send(f9, 6);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_zero("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(fb, -1);
    wait_idle();
    chk(last_frame_cnt == 18, "after_rst_len", last_frame_cnt, 18);

    // short frame: padded or not depending on build
    send(f20, -1);
    wait_idle();
`ifdef ETH_FCS_PAD_EN
    chk(last_frame_cnt == 128, "short_frame_len", last_frame_cnt, 128);
`else
    chk(last_frame_cnt == 28, "short_frame_len", last_frame_cnt, 28);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
